// File: rtl/log2_enc_pipe.sv
// Two-stage pipelined priority encoder: floor-log2 (PRIO_MSB=1) or trailing-zero
// count (PRIO_MSB=0) of an arbitrary word, plus zero and power-of-two flags.
module log2_enc_pipe #(
  parameter int W = 8,
  parameter int G = 4,
  parameter bit PRIO_MSB = 1'b1,
  localparam int LW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [LW-1:0] out_log,
  output logic          out_zero,
  output logic          out_pow2,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int NG = W / G;
  localparam int GL = $clog2(G);

  logic adv1;
  logic adv2;

  // Per-group combinational summary of the incoming word
  logic [NG-1:0] grp_any;
  logic [GL-1:0] grp_idx [NG];
  logic [1:0]    grp_cnt [NG];

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [G-1:0]  bits;
    logic          any_c;
    logic [GL-1:0] idx_c;
    logic [1:0]    cnt_c;

    assign bits = in_data[gi*G +: G];

    // Scan order makes the last hit the preferred one: ascending for MSB, descending for LSB.
    always_comb begin
      any_c = 1'b0;
      idx_c = '0;
      cnt_c = 2'd0;
      for (int j = 0; j < G; j++) begin
        if (bits[PRIO_MSB ? j : G-1-j]) begin
          any_c = 1'b1;
          idx_c = GL'(PRIO_MSB ? j : G-1-j);
          if (cnt_c != 2'd2) cnt_c = cnt_c + 2'd1;
        end
      end
    end

    assign grp_any[gi] = any_c;
    assign grp_idx[gi] = idx_c;
    assign grp_cnt[gi] = cnt_c;
  end

  logic          s1_valid_q, s1_valid_d;
  logic [NG-1:0] s1_any_q, s1_any_d;
  logic [GL-1:0] s1_idx_q [NG];
  logic [GL-1:0] s1_idx_d [NG];
  logic [1:0]    s1_cnt_q [NG];
  logic [1:0]    s1_cnt_d [NG];

  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] out_log_q, out_log_d;
  logic          out_zero_q, out_zero_d;
  logic          out_pow2_q, out_pow2_d;

  assign adv2 = !out_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;
  // Reset empties both stages, so the block is always able to accept while rst is high.
  assign in_ready = adv1 || rst;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_any_d   = s1_any_q;
    s1_idx_d   = s1_idx_q;
    s1_cnt_d   = s1_cnt_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_any_d = grp_any;
        s1_idx_d = grp_idx;
        s1_cnt_d = grp_cnt;
      end
    end
  end

  // Stage 2: pick the winning group and combine saturated counts
  logic          sel_any;
  int            sel_grp;
  logic [GL-1:0] sel_loc;
  int            cnt_sum;

  always_comb begin
    sel_any = 1'b0;
    sel_grp = 0;
    sel_loc = '0;
    cnt_sum = 0;
    for (int g = 0; g < NG; g++) begin
      if (s1_any_q[PRIO_MSB ? g : NG-1-g]) begin
        sel_any = 1'b1;
        sel_grp = PRIO_MSB ? g : NG-1-g;
        sel_loc = s1_idx_q[PRIO_MSB ? g : NG-1-g];
      end
      if (cnt_sum + int'(s1_cnt_q[g]) >= 2) cnt_sum = 2;
      else cnt_sum = cnt_sum + int'(s1_cnt_q[g]);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_log_d   = out_log_q;
    out_zero_d  = out_zero_q;
    out_pow2_d  = out_pow2_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_log_d  = sel_any ? LW'(sel_grp * G + int'(sel_loc)) : '0;
        out_zero_d = !sel_any;
        out_pow2_d = (cnt_sum == 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_any_q    <= '0;
      for (int g = 0; g < NG; g++) begin
        s1_idx_q[g] <= '0;
        s1_cnt_q[g] <= '0;
      end
      out_valid_q <= 1'b0;
      out_log_q   <= '0;
      out_zero_q  <= 1'b1;
      out_pow2_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_any_q    <= s1_any_d;
      s1_idx_q    <= s1_idx_d;
      s1_cnt_q    <= s1_cnt_d;
      out_valid_q <= out_valid_d;
      out_log_q   <= out_log_d;
      out_zero_q  <= out_zero_d;
      out_pow2_q  <= out_pow2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_log   = out_log_q;
  assign out_zero  = out_zero_q;
  assign out_pow2  = out_pow2_q;

endmodule

// File: tb/tb_log2_enc_pipe.sv
// Scoreboard bench for log2_enc_pipe: directed vectors on 8-bit MSB/LSB instances,
// random sweep with a reference model on 32-bit MSB/LSB instances.
module tb_log2_enc_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] d8;
  logic       v8, r8;
  logic       ir_a, ov_a, oz_a, op_a;
  logic [2:0] ol_a;
  logic       ir_b, ov_b, oz_b, op_b;
  logic [2:0] ol_b;

  logic [31:0] d32;
  logic        v32, r32;
  logic        ir_c, ov_c, oz_c, op_c;
  logic [4:0]  ol_c;
  logic        ir_d, ov_d, oz_d, op_d;
  logic [4:0]  ol_d;

  log2_enc_pipe #(.W(8), .G(4), .PRIO_MSB(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(ir_a),
    .out_log(ol_a), .out_zero(oz_a), .out_pow2(op_a), .out_valid(ov_a), .out_ready(r8));
  log2_enc_pipe #(.W(8), .G(4), .PRIO_MSB(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(ir_b),
    .out_log(ol_b), .out_zero(oz_b), .out_pow2(op_b), .out_valid(ov_b), .out_ready(r8));
  log2_enc_pipe #(.W(32), .G(8), .PRIO_MSB(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_data(d32), .in_valid(v32), .in_ready(ir_c),
    .out_log(ol_c), .out_zero(oz_c), .out_pow2(op_c), .out_valid(ov_c), .out_ready(r32));
  log2_enc_pipe #(.W(32), .G(8), .PRIO_MSB(1'b0)) u_d (
    .clk(clk), .rst(rst), .in_data(d32), .in_valid(v32), .in_ready(ir_d),
    .out_log(ol_d), .out_zero(oz_d), .out_pow2(op_d), .out_valid(ov_d), .out_ready(r32));

  typedef struct {
    logic [4:0] lg;
    logic       zero;
    logic       pow2;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t ea, eb, ec, ed;
  exp_t qa[$], qb[$], qc[$], qd[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   xin = 0;
  bit   lat_flag = 1'b0;
  bit   verbose = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end else if (verbose) begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic chk(input string nm, input bit have, input exp_t e,
                     input logic [4:0] lg, input logic z, input logic p);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected result log=%0d zero=%0d pow2=%0d with none outstanding", nm, lg, z, p);
    end else if (lg !== e.lg || z !== e.zero || p !== e.pow2 || (e.lat && (cyc - e.cyc) != 2)) begin
      errors++;
      $display("FAIL %s got log=%0d zero=%0d pow2=%0d latency=%0d want log=%0d zero=%0d pow2=%0d latency=2",
               nm, lg, z, p, cyc - e.cyc, e.lg, e.zero, e.pow2);
    end else if (verbose) begin
      $display("ok   %s log=%0d zero=%0d pow2=%0d", nm, lg, z, p);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input bit msb);
    exp_t e;
    int n;
    n = 0;
    e.lg = '0;
    e.cyc = 0;
    e.lat = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        n++;
        if (msb || n == 1) e.lg = 5'(i);
      end
    end
    e.zero = (n == 0);
    e.pow2 = (n == 1);
    return e;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    exp_t t;
    bit   have;
    if (!rst) begin
      if (v8 && ir_a) begin
        t = ea; t.cyc = cyc; t.lat = lat_flag; qa.push_back(t);
        t = eb; t.cyc = cyc; t.lat = lat_flag; qb.push_back(t);
      end
      if (v32 && ir_c) begin
        t = ec; t.cyc = cyc; t.lat = 1'b0; qc.push_back(t);
        t = ed; t.cyc = cyc; t.lat = 1'b0; qd.push_back(t);
        xin++;
      end
      if (ov_a && r8) begin
        have = (qa.size() > 0); e = ea; if (have) e = qa.pop_front();
        chk("msb8", have, e, {2'b00, ol_a}, oz_a, op_a);
      end
      if (ov_b && r8) begin
        have = (qb.size() > 0); e = eb; if (have) e = qb.pop_front();
        chk("lsb8", have, e, {2'b00, ol_b}, oz_b, op_b);
      end
      if (ov_c && r32) begin
        have = (qc.size() > 0); e = ec; if (have) e = qc.pop_front();
        chk("msb32", have, e, ol_c, oz_c, op_c);
      end
      if (ov_d && r32) begin
        have = (qd.size() > 0); e = ed; if (have) e = qd.pop_front();
        chk("lsb32", have, e, ol_d, oz_d, op_d);
      end
    end
  end

  task automatic set8(input logic [7:0] d, input int la, input int lb, input bit z, input bit p);
    d8 = d;
    ea.lg = 5'(la); ea.zero = z; ea.pow2 = p; ea.cyc = 0; ea.lat = 1'b0;
    eb.lg = 5'(lb); eb.zero = z; eb.pow2 = p; eb.cyc = 0; eb.lat = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the operand has been accepted.
  task automatic send(input logic [7:0] d, input int la, input int lb, input bit z, input bit p);
    int n;
    n = 0;
    set8(d, la, lb, z, p);
    v8 = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ir_a && n < 50);
    if (!ir_a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%02h in_ready=%0d want 1", d, ir_a);
    end
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] gen32();
    logic [31:0] one;
    one = 32'h1;
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return one << $urandom_range(0, 31);
      2: return $urandom & $urandom & $urandom;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int stale;
    int n;
    rst = 1'b1;
    v8 = 1'b0; r8 = 1'b1; d8 = '0;
    v32 = 1'b0; r32 = 1'b1; d32 = '0;
    set8(8'h00, 0, 0, 1'b1, 1'b0);
    ec = model(32'h0, 1'b1);
    ed = model(32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    expect_eq("rst_out_valid", ov_a, 0);
    expect_eq("rst_out_zero", oz_a, 1);
    expect_eq("rst_out_log", ol_a, 0);
    expect_eq("rst_out_pow2", op_a, 0);
    expect_eq("rst_in_ready", ir_a, 1);
    idle(1);

    // Single operands with latency checked
    lat_flag = 1'b1;
    send(8'h01, 0, 0, 1'b0, 1'b1);
    idle(4);
    send(8'h80, 7, 7, 1'b0, 1'b1);
    idle(4);
    lat_flag = 1'b0;
    send(8'h2C, 5, 2, 1'b0, 1'b0);
    send(8'h00, 0, 0, 1'b1, 1'b0);
    send(8'hFF, 7, 0, 1'b0, 1'b0);
    send(8'h90, 7, 4, 1'b0, 1'b0);
    idle(4);

    // Back-to-back one-hot stream; latency 2 on each means no bubbles
    lat_flag = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(1 << i), i, i, 1'b0, 1'b1);
    idle(4);
    lat_flag = 1'b0;

    // Backpressure: third offer blocked while both stages are full
    r8 = 1'b0;
    v8 = 1'b1;
    set8(8'h04, 2, 2, 1'b0, 1'b1);
    @(negedge clk); expect_eq("bp_in_ready_1", ir_a, 1);
    @(posedge clk); #1;
    set8(8'h10, 4, 4, 1'b0, 1'b1);
    @(negedge clk); expect_eq("bp_in_ready_2", ir_a, 1);
    @(posedge clk); #1;
    set8(8'h40, 6, 6, 1'b0, 1'b1);
    @(negedge clk); expect_eq("bp_in_ready_3", ir_a, 0);
    expect_eq("bp_out_valid_held", ov_a, 1);
    @(posedge clk); #1;
    expect_eq("bp_out_log_held", ol_a, 2);
    r8 = 1'b1;
    @(negedge clk); expect_eq("bp_in_ready_4", ir_a, 1);
    @(posedge clk); #1;
    v8 = 1'b0;
    idle(5);
    expect_eq("bp_drained", qa.size() + qb.size(), 0);

    // Reset with two operands in flight; input during reset is ignored
    r8 = 1'b0;
    send(8'h08, 3, 3, 1'b0, 1'b1);
    send(8'h20, 5, 5, 1'b0, 1'b1);
    rst = 1'b1;
    v8 = 1'b1;
    d8 = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    v8 = 1'b0;
    qa.delete();
    qb.delete();
    expect_eq("mid_rst_out_valid", ov_a, 0);
    expect_eq("mid_rst_in_ready", ir_a, 1);
    expect_eq("mid_rst_out_zero", oz_a, 1);
    expect_eq("mid_rst_out_log", ol_a, 0);
    r8 = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov_a || ov_b) stale++;
    end
    expect_eq("mid_rst_no_stale", stale, 0);
    @(posedge clk); #1;

    // Random sweep on the 32-bit instances
    verbose = 1'b0;
    n = 0;
    while (xin < 10000 && n < 60000) begin
      v32 = ($urandom_range(0, 99) < 70);
      d32 = gen32();
      ec = model(d32, 1'b1);
      ed = model(d32, 1'b0);
      r32 = ($urandom_range(0, 99) < 70);
      @(posedge clk); #1;
      n++;
    end
    v32 = 1'b0;
    r32 = 1'b1;
    idle(6);
    verbose = 1'b1;
    expect_eq("rand_transfers_done", (xin >= 10000) ? 1 : 0, 1);
    expect_eq("rand_msb_drained", qc.size(), 0);
    expect_eq("rand_lsb_drained", qd.size(), 0);
    expect_eq("dir_drained", qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/log2_enc_pipe.md
Name: log2_enc_pipe

Overview:
- Parametrised, pipelined floor-log2 / priority encoder: the next generation of the team's 8-bit one-hot-to-binary log encoder.
- Accepts any input pattern, not only one-hot. Reports:
  - the index of the highest (or lowest) set bit,
  - a zero flag,
  - a power-of-two flag.
- Two-stage registered pipeline with valid/ready handshakes on both sides. Sits between a data producer and arithmetic consumers (normalisers, shifters).

Parameters:
- W, 8, input data width; power of two, 2..256.
- G, 4, group size for the stage-1 split; power of two, 2 <= G <= W, W divisible by G.
- PRIO_MSB, 1, 1 = index of highest set bit (floor log2); 0 = index of lowest set bit (trailing-zero count).
- LW, $clog2(W), output index width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  W  operand.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- out_log  out  LW  bit index result.
- out_zero  out  1  operand was all zeros.
- out_pow2  out  1  operand had exactly one bit set.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on rising clk.
- Reset values:
  - s1_valid = 0 and out_valid = 0.
  - out_log = 0, out_zero = 1, out_pow2 = 0.
  - Internal data registers = 0.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1, captured on input transfer:
  - Split in_data into W/G groups.
  - Per group, register an any-bit flag, the local index (log2(G) bits) selected by PRIO_MSB, and a per-group popcount saturated at 2.
- Stage 2:
  - Select the highest (PRIO_MSB=1) or lowest (PRIO_MSB=0) group with the any-bit flag set.
  - out_log = {group index, local index}.
  - out_zero = no group flag set.
  - out_pow2 = total saturated count == 1.
  - When out_zero = 1, out_log = 0 and out_pow2 = 0.
- Advance rules:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1; it is combinational from out_ready (documented path).
  - On adv2: out_valid <= s1_valid and output registers load from stage 1.
  - On adv1: s1_valid <= in_valid and stage-1 registers load when in_valid.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no stall.
  - Throughput 1 result/cycle while out_ready = 1.
- Stall: out_valid && !out_ready holds all output registers stable. Stage 1 still fills if empty; in_ready drops only when both stages are full.
- Ordering: results leave in input order; no drop or duplication under any backpressure pattern.
- Simultaneous events:
  - With both stages full, an output transfer plus an input transfer in the same cycle shifts the pipe, keeping two entries.
  - in_valid while rst = 1 is ignored.
- Reset mid-operation: the cycle after rst, both valids are 0 and in-flight operands are discarded. in_ready = 1 during and after reset.
- Flags when in_valid = 0: out_* data fields are don't-care for the consumer while out_valid = 0. Implementation holds the last value.
- No latches, no combinational loops, fully synchronous.

Test Plan:
- W=8, G=4, PRIO_MSB=1, out_ready=1:
  - 8'h01 -> out_log 0, pow2 1, zero 0, out_valid exactly 2 cycles after accept.
  - 8'h80 -> out_log 7, pow2 1.
- Same config, 8'h2C -> out_log 5, pow2 0, zero 0.
  - PRIO_MSB=0 instance with 8'h2C -> out_log 2.
  - 8'h00 -> zero 1, out_log 0, pow2 0.
- Streaming, back-to-back one-hot 8'h01..8'h80 shifted each cycle -> out_log 0..7 on consecutive cycles, no bubbles.
- Backpressure:
  - out_ready=0, offer 8'h04, 8'h10, 8'h40 on consecutive cycles -> first two accepted, in_ready=0 on the third.
  - Raise out_ready -> results 2, 4, 6 in order, none lost.
- Reset mid-flight: two operands in pipe, assert rst 1 cycle -> next cycle out_valid=0, s1 empty, in_ready=1, out_zero=1; no stale result appears later.
- W=32, G=8 random sweep vs reference model (floor log2, ctz, popcount==1) with random in_valid/out_ready -> zero mismatches over 10k transfers.
